// File: rtl/axil_arbiter_2x1_if.sv
// AXI4-Lite channel bundle shared by both requesters and the downstream port.
// Latency: none (signal container only).
// Backpressure: carries the standard per-channel valid/ready pairs.
// Ports: aw*/w*/b*/ar*/r* AXI4-Lite channels.
// master modport = the side that issues transactions.
// slave modport = the side that accepts them.
interface axil_arbiter_2x1_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_arbiter_2x1.sv
// Two-requester AXI4-Lite arbiter; write and read paths arbitrated independently.
// Latency: 1 cycle grant; AW/W/AR and B/R forwarded combinationally once granted.
// Backpressure: downstream ready/valid routed straight to the granted requester only.
// Ports: clk, rst (sync, active-low), s0/s1 requester ports (slave modport),
// m downstream port (master modport).
// Build option: define AXIL_ARB_FIXED_PRIO_EN for fixed priority (s0 wins
// contention); otherwise round-robin on a per-path last-grant bit.
module axil_arbiter_2x1 #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    axil_arbiter_2x1_if.slave    s0,
    axil_arbiter_2x1_if.slave    s1,
    axil_arbiter_2x1_if.master   m
);
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t wstate;
    rstate_t rstate;
    logic    wgnt;
    logic    rgnt;
    logic    aw_done;
    logic    w_done;
    logic    wpick;
    logic    rpick;

    logic wreq0;
    logic wreq1;
    assign wreq0 = s0.awvalid | s0.wvalid;
    assign wreq1 = s1.awvalid | s1.wvalid;

    logic w_addr_ph;
    logic w_resp_ph;
    logic r_addr_ph;
    logic r_data_ph;
    assign w_addr_ph = (wstate == W_ADDR);
    assign w_resp_ph = (wstate == W_RESP);
    assign r_addr_ph = (rstate == R_ADDR);
    assign r_data_ph = (rstate == R_DATA);

`ifdef AXIL_ARB_FIXED_PRIO_EN
    // s0 wins whenever it requests; s1 only when alone.
    assign wpick = ~wreq0;
    assign rpick = ~s0.arvalid;
`else
    logic wlast;
    logic rlast;
    // On contention grant whoever did not win last; a sole requester wins.
    assign wpick = (wreq0 & wreq1) ? ~wlast : wreq1;
    assign rpick = (s0.arvalid & s1.arvalid) ? ~rlast : s1.arvalid;
`endif

    // Write path forwarding. A channel's valid/ready are masked once its
    // handshake has happened so AW and W each transfer exactly once.
    assign m.awvalid = w_addr_ph & ~aw_done & (wgnt ? s1.awvalid : s0.awvalid);
    assign m.awaddr  = {ADDR_WIDTH{w_addr_ph}} & (wgnt ? s1.awaddr : s0.awaddr);
    assign m.awprot  = {3{w_addr_ph}} & (wgnt ? s1.awprot : s0.awprot);
    assign m.wvalid  = w_addr_ph & ~w_done & (wgnt ? s1.wvalid : s0.wvalid);
    assign m.wdata   = {DATA_WIDTH{w_addr_ph}} & (wgnt ? s1.wdata : s0.wdata);
    assign m.wstrb   = {(DATA_WIDTH/8){w_addr_ph}} & (wgnt ? s1.wstrb : s0.wstrb);
    assign m.bready  = w_resp_ph & (wgnt ? s1.bready : s0.bready);

    assign s0.awready = w_addr_ph & ~wgnt & ~aw_done & m.awready;
    assign s1.awready = w_addr_ph &  wgnt & ~aw_done & m.awready;
    assign s0.wready  = w_addr_ph & ~wgnt & ~w_done & m.wready;
    assign s1.wready  = w_addr_ph &  wgnt & ~w_done & m.wready;
    assign s0.bvalid  = w_resp_ph & ~wgnt & m.bvalid;
    assign s1.bvalid  = w_resp_ph &  wgnt & m.bvalid;
    assign s0.bresp   = {2{w_resp_ph & ~wgnt}} & m.bresp;
    assign s1.bresp   = {2{w_resp_ph &  wgnt}} & m.bresp;

    // Read path forwarding.
    assign m.arvalid = r_addr_ph & (rgnt ? s1.arvalid : s0.arvalid);
    assign m.araddr  = {ADDR_WIDTH{r_addr_ph}} & (rgnt ? s1.araddr : s0.araddr);
    assign m.arprot  = {3{r_addr_ph}} & (rgnt ? s1.arprot : s0.arprot);
    assign m.rready  = r_data_ph & (rgnt ? s1.rready : s0.rready);

    assign s0.arready = r_addr_ph & ~rgnt & m.arready;
    assign s1.arready = r_addr_ph &  rgnt & m.arready;
    assign s0.rvalid  = r_data_ph & ~rgnt & m.rvalid;
    assign s1.rvalid  = r_data_ph &  rgnt & m.rvalid;
    assign s0.rdata   = {DATA_WIDTH{r_data_ph & ~rgnt}} & m.rdata;
    assign s1.rdata   = {DATA_WIDTH{r_data_ph &  rgnt}} & m.rdata;
    assign s0.rresp   = {2{r_data_ph & ~rgnt}} & m.rresp;
    assign s1.rresp   = {2{r_data_ph &  rgnt}} & m.rresp;

    logic aw_hs;
    logic w_hs;
    assign aw_hs = m.awvalid & m.awready;
    assign w_hs  = m.wvalid & m.wready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wstate  <= W_IDLE;
            wgnt    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            wlast   <= 1'b1;
`endif
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (wreq0 | wreq1) begin
                        wgnt   <= wpick;
                        wstate <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done | aw_hs) & (w_done | w_hs)) wstate <= W_RESP;
                end
                W_RESP: begin
                    if (m.bvalid & m.bready) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
                        wlast   <= wgnt;
`endif
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rstate <= R_IDLE;
            rgnt   <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            rlast  <= 1'b1;
`endif
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s0.arvalid | s1.arvalid) begin
                        rgnt   <= rpick;
                        rstate <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m.arvalid & m.arready) rstate <= R_DATA;
                end
                R_DATA: begin
                    if (m.rvalid & m.rready) begin
`ifndef AXIL_ARB_FIXED_PRIO_EN
                        rlast  <= rgnt;
`endif
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Bench for axil_arbiter_2x1: scoreboard of expected downstream requests and
// per-requester responses, plus cycle-accurate directed checks.
// Downstream is a simple always-ready AXI-Lite slave whose responses derive from the address.
module tb_axil_arbiter_2x1;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    axil_arbiter_2x1_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) s0 ();
    axil_arbiter_2x1_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) s1 ();
    axil_arbiter_2x1_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) m ();

    axil_arbiter_2x1 #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s0(s0), .s1(s1), .m(m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard queues.
    logic [26:0] exp_aw0[$];
    logic [26:0] exp_aw1[$];
    logic [35:0] exp_w0[$];
    logic [35:0] exp_w1[$];
    logic [26:0] exp_ar0[$];
    logic [26:0] exp_ar1[$];
    logic [1:0]  exp_b0[$];
    logic [1:0]  exp_b1[$];
    logic [33:0] exp_r0[$];
    logic [33:0] exp_r1[$];
    bit          exp_gnt_w[$];
    bit          exp_gnt_r[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Downstream slave: always ready, responds one cycle after handshake.
    logic        aw_seen;
    logic        w_seen;
    logic [23:0] b_addr;
    always @(posedge clk) begin
        if (!rst) begin
            m.bvalid <= 1'b0; m.bresp <= 2'b00;
            m.rvalid <= 1'b0; m.rdata <= 32'h0; m.rresp <= 2'b00;
            aw_seen  <= 1'b0; w_seen <= 1'b0; b_addr <= 24'h0;
        end else begin
            if (m.bvalid && m.bready) m.bvalid <= 1'b0;
            if (m.rvalid && m.rready) m.rvalid <= 1'b0;
            if (m.arvalid && m.arready) begin
                m.rvalid <= 1'b1;
                m.rdata  <= {8'hA5, m.araddr};
                m.rresp  <= m.araddr[17:16];
            end
            if ((aw_seen || (m.awvalid && m.awready)) && (w_seen || (m.wvalid && m.wready))) begin
                m.bvalid <= 1'b1;
                m.bresp  <= aw_seen ? b_addr[17:16] : m.awaddr[17:16];
                aw_seen  <= 1'b0;
                w_seen   <= 1'b0;
            end else begin
                if (m.awvalid && m.awready) begin aw_seen <= 1'b1; b_addr <= m.awaddr; end
                if (m.wvalid && m.wready) w_seen <= 1'b1;
            end
        end
    end

    // Monitor: compare every handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (m.awvalid && m.awready) begin
                chk("aw_one_grant", {s0.awready, s1.awready} == 2'b01 || {s0.awready, s1.awready} == 2'b10, 1);
                chk("aw_gnt_avail", exp_gnt_w.size() != 0, 1);
                if (exp_gnt_w.size() != 0) chk("aw_gnt", s1.awready, exp_gnt_w.pop_front());
                if (s1.awready) begin
                    if (exp_aw1.size() != 0) chk("m_aw_s1", {m.awprot, m.awaddr}, exp_aw1.pop_front());
                end else if (exp_aw0.size() != 0) chk("m_aw_s0", {m.awprot, m.awaddr}, exp_aw0.pop_front());
            end
            if (m.wvalid && m.wready) begin
                if (s1.wready) begin
                    if (exp_w1.size() != 0) chk("m_w_s1", {m.wstrb, m.wdata}, exp_w1.pop_front());
                end else if (exp_w0.size() != 0) chk("m_w_s0", {m.wstrb, m.wdata}, exp_w0.pop_front());
            end
            if (m.arvalid && m.arready) begin
                chk("ar_one_grant", {s0.arready, s1.arready} == 2'b01 || {s0.arready, s1.arready} == 2'b10, 1);
                chk("ar_gnt_avail", exp_gnt_r.size() != 0, 1);
                if (exp_gnt_r.size() != 0) chk("ar_gnt", s1.arready, exp_gnt_r.pop_front());
                if (s1.arready) begin
                    if (exp_ar1.size() != 0) chk("m_ar_s1", {m.arprot, m.araddr}, exp_ar1.pop_front());
                end else if (exp_ar0.size() != 0) chk("m_ar_s0", {m.arprot, m.araddr}, exp_ar0.pop_front());
            end
            if (s0.bvalid && s0.bready) begin
                chk("b0_avail", exp_b0.size() != 0, 1);
                if (exp_b0.size() != 0) chk("s0_bresp", s0.bresp, exp_b0.pop_front());
            end
            if (s1.bvalid && s1.bready) begin
                chk("b1_avail", exp_b1.size() != 0, 1);
                if (exp_b1.size() != 0) chk("s1_bresp", s1.bresp, exp_b1.pop_front());
            end
            if (s0.rvalid && s0.rready) begin
                chk("r0_avail", exp_r0.size() != 0, 1);
                if (exp_r0.size() != 0) chk("s0_r", {s0.rresp, s0.rdata}, exp_r0.pop_front());
            end
            if (s1.rvalid && s1.rready) begin
                chk("r1_avail", exp_r1.size() != 0, 1);
                if (exp_r1.size() != 0) chk("s1_r", {s1.rresp, s1.rdata}, exp_r1.pop_front());
            end
        end
    end

    function automatic logic any_out();
        return |{m.awaddr, m.awprot, m.awvalid, m.wdata, m.wstrb, m.wvalid, m.bready,
                 m.araddr, m.arprot, m.arvalid, m.rready,
                 s0.awready, s0.wready, s0.bresp, s0.bvalid, s0.arready, s0.rdata, s0.rresp, s0.rvalid,
                 s1.awready, s1.wready, s1.bresp, s1.bvalid, s1.arready, s1.rdata, s1.rresp, s1.rvalid};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive a write (AW+W together) and push its expectations.
    task automatic put_wr(input int who, input logic [23:0] a, input logic [31:0] d, input logic [3:0] st);
        logic [2:0] p;
        p = (who == 0) ? 3'b001 : 3'b010;
        if (who == 0) begin
            s0.awaddr = a; s0.awprot = p; s0.awvalid = 1'b1;
            s0.wdata = d; s0.wstrb = st; s0.wvalid = 1'b1;
            exp_aw0.push_back({p, a}); exp_w0.push_back({st, d}); exp_b0.push_back(a[17:16]);
        end else begin
            s1.awaddr = a; s1.awprot = p; s1.awvalid = 1'b1;
            s1.wdata = d; s1.wstrb = st; s1.wvalid = 1'b1;
            exp_aw1.push_back({p, a}); exp_w1.push_back({st, d}); exp_b1.push_back(a[17:16]);
        end
        exp_gnt_w.push_back(who != 0);
    endtask

    task automatic clr_wr(input int who);
        if (who == 0) begin s0.awvalid = 1'b0; s0.wvalid = 1'b0; end
        else begin s1.awvalid = 1'b0; s1.wvalid = 1'b0; end
    endtask

    // Drive a read request; the grant order is pushed by the caller.
    task automatic put_rd(input int who, input logic [23:0] a, input bit want_r);
        logic [2:0] p;
        logic [33:0] r;
        p = (who == 0) ? 3'b100 : 3'b110;
        r = {a[17:16], 8'hA5, a};
        if (who == 0) begin
            s0.araddr = a; s0.arprot = p; s0.arvalid = 1'b1;
            exp_ar0.push_back({p, a});
            if (want_r) exp_r0.push_back(r);
        end else begin
            s1.araddr = a; s1.arprot = p; s1.arvalid = 1'b1;
            exp_ar1.push_back({p, a});
            if (want_r) exp_r1.push_back(r);
        end
    endtask

    task automatic clr_rd(input int who);
        if (who == 0) s0.arvalid = 1'b0;
        else s1.arvalid = 1'b0;
    endtask

    // Full read request: hold AR until accepted (bounded), then drop it.
    task automatic do_read(input int who, input logic [23:0] a);
        bit got;
        got = 1'b0;
        put_rd(who, a, 1'b1);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if ((who == 0) ? s0.arready : s1.arready) begin
                got = 1'b1;
                break;
            end
        end
        chk("ar_accept_timeout", got, 1);
        cyc();
        clr_rd(who);
    endtask

    initial begin
        rst = 1'b0;
        n_tests = 0;
        n_fail = 0;
        s0.awaddr = '0; s0.awprot = '0; s0.awvalid = 1'b0; s0.wdata = '0; s0.wstrb = '0;
        s0.wvalid = 1'b0; s0.bready = 1'b1; s0.araddr = '0; s0.arprot = '0; s0.arvalid = 1'b0;
        s0.rready = 1'b1;
        s1.awaddr = '0; s1.awprot = '0; s1.awvalid = 1'b0; s1.wdata = '0; s1.wstrb = '0;
        s1.wvalid = 1'b0; s1.bready = 1'b1; s1.araddr = '0; s1.arprot = '0; s1.arvalid = 1'b0;
        s1.rready = 1'b1;
        m.awready = 1'b1; m.wready = 1'b1; m.arready = 1'b1;

        // Reset state.
        repeat (3) cyc();
        @(negedge clk);
        chk("reset_outputs_zero", any_out(), 0);
        cyc();
        rst = 1'b1;

        // Single write from s0.
        cyc();
        put_wr(0, 24'h010004, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("w1_c0_idle", m.awvalid, 0);
        cyc();
        @(negedge clk);
        chk("w1_c1_fwd", {m.awvalid, m.wvalid, s0.awready, s0.wready}, 4'hF);
        chk("w1_c1_s1_quiet", {s1.awready, s1.wready, s1.bvalid}, 0);
        cyc();
        clr_wr(0);
        @(negedge clk);
        chk("w1_c2_bvalid", {s0.bvalid, m.bready, s1.bvalid}, 3'b110);
        cyc();
        @(negedge clk);
        chk("w1_c3_idle", {m.awvalid, m.wvalid, s0.bvalid}, 0);

        // s1: AW at cycle 0, W only at cycle 3.
        cyc();
        put_wr(1, 24'h020008, 32'h12345678, 4'h3);
        s1.wvalid = 1'b0;
        cyc();
        @(negedge clk);
        chk("aw1_c1", {m.awvalid, m.wvalid, s1.awready}, 3'b101);
        cyc();
        s1.awvalid = 1'b0;
        @(negedge clk);
        chk("aw1_c2", {m.awvalid, m.wvalid, s1.bvalid}, 0);
        cyc();
        s1.wvalid = 1'b1;
        @(negedge clk);
        chk("aw1_c3_w", {m.wvalid, s1.wready, s1.bvalid}, 3'b110);
        cyc();
        s1.wvalid = 1'b0;
        @(negedge clk);
        chk("aw1_c4_b", {s1.bvalid, s0.bvalid}, 2'b10);
        cyc();
        @(negedge clk);
        chk("aw1_c5_idle", s1.bvalid, 0);

        // Read contention: both requesters read continuously.
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 8; i++) exp_gnt_r.push_back(i >= 4);
`else
        for (int i = 0; i < 8; i++) exp_gnt_r.push_back(i[0]);
`endif
        fork
            begin for (int k = 0; k < 4; k++) do_read(0, 24'h000000); end
            begin for (int k = 0; k < 4; k++) do_read(1, 24'h020000); end
        join
        repeat (4) cyc();

        // Concurrent s0 write and s1 read.
        put_wr(0, 24'h010010, 32'hCAFEF00D, 4'hF);
        put_rd(1, 24'h030004, 1'b1);
        exp_gnt_r.push_back(1'b1);
        cyc();
        @(negedge clk);
        chk("cc_c1_fwd", {m.awvalid, m.wvalid, m.arvalid, s0.awready, s1.arready}, 5'h1F);
        cyc();
        clr_wr(0);
        clr_rd(1);
        @(negedge clk);
        chk("cc_c2_resp", {s0.bvalid, s1.rvalid, s1.bvalid, s0.rvalid}, 4'b1100);
        cyc();

        // B backpressure from s0.
        s0.bready = 1'b0;
        put_wr(0, 24'h000100, 32'h0BADCAFE, 4'hC);
        cyc();
        cyc();
        clr_wr(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_stall", {s0.bvalid, m.bvalid, m.bready}, 3'b110);
            cyc();
        end
        s0.bready = 1'b1;
        @(negedge clk);
        chk("bp_release", {s0.bvalid, m.bready}, 2'b11);
        cyc();
        @(negedge clk);
        chk("bp_done", s0.bvalid, 0);

        // Reset during a read data phase; s0 read first so last grant is s0.
        exp_gnt_r.push_back(1'b0);
        do_read(0, 24'h000080);
        repeat (3) cyc();
        s1.rready = 1'b0;
        put_rd(1, 24'h020000, 1'b0);
        exp_gnt_r.push_back(1'b1);
        cyc();
        @(negedge clk);
        chk("rr_c1_ar", m.arvalid, 1);
        cyc();
        clr_rd(1);
        @(negedge clk);
        chk("rr_c2_rvalid", s1.rvalid, 1);
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("rst_mid_outputs_zero", any_out(), 0);
        cyc();
        rst = 1'b1;
        s1.rready = 1'b1;
        exp_gnt_r.push_back(1'b0);
        exp_gnt_r.push_back(1'b1);
        fork
            do_read(0, 24'h000040);
            do_read(1, 24'h020040);
        join
        repeat (6) cyc();

        chk("sb_drained", exp_aw0.size() + exp_aw1.size() + exp_w0.size() + exp_w1.size() +
            exp_ar0.size() + exp_ar1.size() + exp_b0.size() + exp_b1.size() +
            exp_r0.size() + exp_r1.size() + exp_gnt_w.size() + exp_gnt_r.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
